// File: rtl/frame_rx_pkg.sv
// Shared types and code/geometry helpers for the frame_rx serial receiver.
package frame_rx_pkg;

  typedef enum logic [1:0] {SCAN, IDLE, DATA, CHECK} state_e;

  localparam int unsigned MaxChunk = 256;

  function automatic int unsigned chunk_len(int unsigned lines, int unsigned cpc);
    return lines * cpc;
  endfunction

  function automatic int unsigned chunks_per_frame(int unsigned length, int unsigned clen);
    return (length + clen - 1) / clen;
  endfunction

  function automatic int unsigned length_pad(int unsigned length, int unsigned clen);
    return chunks_per_frame(length, clen) * clen;
  endfunction

  function automatic logic [MaxChunk-1:0] lane_ones(int unsigned lines);
    return (MaxChunk'(1) << lines) - MaxChunk'(1);
  endfunction

  // Oldest clock ends up in the MSBs, matching the receive shift direction.
  function automatic logic [MaxChunk-1:0] idle_code(int unsigned lines, int unsigned cpc);
    logic [MaxChunk-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < cpc; k++) begin
      c = c << lines;
      if (k < cpc / 2) c = c | lane_ones(lines);
    end
    return c;
  endfunction

  function automatic logic [MaxChunk-1:0] start_code(int unsigned lines, int unsigned cpc);
    logic [MaxChunk-1:0] c;
    c = '0;
    for (int unsigned k = 0; k < cpc; k++) begin
      c = c << lines;
      if (k % 2 == 0) c = c | lane_ones(lines);
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_rx_if.sv
// Valid/ready frame output bundle between frame_rx and its consumer.
interface frame_rx_if #(
  parameter int unsigned LENGTH = 128
);
  logic [LENGTH-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/frame_rx_hold.sv
// Single-entry valid/ready holding register; drops and flags frames arriving while full.
module frame_rx_hold
  import frame_rx_pkg::*;
#(
  parameter int unsigned LENGTH = 128,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LENGTH-1:0] data,
  frame_rx_if.master        m,
  output logic              overflow,
  output logic [CNT_W-1:0]  frame_cnt
);

  logic              valid_q;
  logic              overflow_q;
  logic [LENGTH-1:0] data_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              free;

  // A same-cycle handshake frees the slot for the incoming frame.
  assign free = !valid_q || m.m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
    end else begin
      overflow_q <= load && !free;
      if (load && free) begin
        valid_q <= 1'b1;
        data_q  <= data;
        cnt_q   <= cnt_q + 1'b1;
      end else if (valid_q && m.m_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign m.m_valid = valid_q;
  assign m.m_data  = data_q;
  assign overflow  = overflow_q;
  assign frame_cnt = cnt_q;

endmodule

// File: rtl/frame_rx.sv
// Multi-lane serial frame receiver with header-based alignment and lock qualification.
// Define FRAME_CHECK_EN to append and verify an XOR check chunk after each payload.
module frame_rx
  import frame_rx_pkg::*;
#(
  parameter int unsigned LENGTH        = 128,
  parameter int unsigned LINES         = 3,
  parameter int unsigned CLK_PER_CHUNK = 4,
  parameter int unsigned LOCK_COUNT    = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LINES-1:0] d,
  output logic             rx_locked,
  output logic             rx_err,
  frame_rx_if.master       m,
  output logic             overflow,
  output logic             check_err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int unsigned CLEN   = chunk_len(LINES, CLK_PER_CHUNK);
  localparam int unsigned NCHUNK = chunks_per_frame(LENGTH, CLEN);
  localparam int unsigned LPAD   = length_pad(LENGTH, CLEN);
  localparam int unsigned PW     = (CLK_PER_CHUNK > 1) ? $clog2(CLK_PER_CHUNK) : 1;
  localparam int unsigned IW     = $clog2(NCHUNK + 1);

  localparam logic [CLEN-1:0] IDLE_CODE  = CLEN'(idle_code(LINES, CLK_PER_CHUNK));
  localparam logic [CLEN-1:0] START_CODE = CLEN'(start_code(LINES, CLK_PER_CHUNK));

  state_e            state_q;
  logic [CLEN-1:0]   chunk_q;
  logic [PW-1:0]     phase_q;
  logic [7:0]        good_q;
  logic [IW-1:0]     idx_q;
  logic              frame_ok_q;
  logic              locked_q;
  logic [LPAD-1:0]   acc_q;
  logic [LPAD-1:0]   acc_next;
  logic [CNT_W-1:0]  err_cnt_q;
  logic [CNT_W-1:0]  err_inc;
  logic [7:0]        good_inc;
  logic              boundary;
  logic              is_idle;
  logic              is_start;
  logic              last_chunk;
  logic              done;
  logic [LENGTH-1:0] done_data;
`ifdef FRAME_CHECK_EN
  logic [CLEN-1:0]   xor_q;
  logic              check_err_q;
`endif

  assign boundary   = phase_q == PW'(CLK_PER_CHUNK - 1);
  assign is_idle    = chunk_q == IDLE_CODE;
  assign is_start   = chunk_q == START_CODE;
  assign last_chunk = idx_q == IW'(NCHUNK - 1);
  assign acc_next   = (acc_q << CLEN) | LPAD'(chunk_q);
  assign err_inc    = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
  assign good_inc   = (good_q == 8'hFF) ? good_q : good_q + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SCAN;
      chunk_q     <= '0;
      phase_q     <= '0;
      good_q      <= '0;
      idx_q       <= '0;
      frame_ok_q  <= 1'b0;
      locked_q    <= 1'b0;
      acc_q       <= '0;
      err_cnt_q   <= '0;
`ifdef FRAME_CHECK_EN
      xor_q       <= '0;
      check_err_q <= 1'b0;
`endif
    end else begin
      chunk_q <= (chunk_q << LINES) | CLEN'(d);
      phase_q <= boundary ? '0 : phase_q + 1'b1;
`ifdef FRAME_CHECK_EN
      check_err_q <= 1'b0;
`endif
      if (state_q != SCAN && good_q >= 8'(LOCK_COUNT)) locked_q <= 1'b1;

      unique case (state_q)
        SCAN: begin
          // Sliding search: a match defines the chunk boundary from here on.
          if (is_idle || is_start) begin
            phase_q    <= '0;
            good_q     <= 8'd1;
            locked_q   <= 1'b0;
            frame_ok_q <= 1'b0;
            idx_q      <= '0;
            acc_q      <= '0;
`ifdef FRAME_CHECK_EN
            xor_q      <= '0;
`endif
            state_q    <= is_start ? DATA : IDLE;
          end
        end
        IDLE: begin
          if (boundary) begin
            if (is_idle || is_start) begin
              good_q <= good_inc;
              if (is_start) begin
                state_q    <= DATA;
                frame_ok_q <= locked_q;
                idx_q      <= '0;
                acc_q      <= '0;
`ifdef FRAME_CHECK_EN
                xor_q      <= '0;
`endif
              end
            end else begin
              state_q   <= SCAN;
              locked_q  <= 1'b0;
              good_q    <= '0;
              err_cnt_q <= err_inc;
            end
          end
        end
        DATA: begin
          if (boundary) begin
            acc_q <= acc_next;
            idx_q <= idx_q + 1'b1;
`ifdef FRAME_CHECK_EN
            xor_q <= xor_q ^ chunk_q;
            if (last_chunk) state_q <= CHECK;
`else
            if (last_chunk) state_q <= IDLE;
`endif
          end
        end
`ifdef FRAME_CHECK_EN
        CHECK: begin
          if (boundary) begin
            state_q <= IDLE;
            if (frame_ok_q && chunk_q != xor_q) begin
              check_err_q <= 1'b1;
              err_cnt_q   <= err_inc;
            end
          end
        end
`endif
        default: state_q <= SCAN;
      endcase
    end
  end

  // Frames that started while unlocked are received but never handed to the holding register.
  always_comb begin
    done      = 1'b0;
`ifdef FRAME_CHECK_EN
    done_data = acc_q[LENGTH-1:0];
    if (state_q == CHECK && boundary && frame_ok_q && chunk_q == xor_q) done = 1'b1;
`else
    done_data = acc_next[LENGTH-1:0];
    if (state_q == DATA && boundary && last_chunk && frame_ok_q) done = 1'b1;
`endif
  end

  frame_rx_hold #(
    .LENGTH (LENGTH),
    .CNT_W  (CNT_W)
  ) u_hold (
    .clk       (clk),
    .rst       (rst),
    .load      (done),
    .data      (done_data),
    .m         (m),
    .overflow  (overflow),
    .frame_cnt (frame_cnt)
  );

  assign rx_locked = locked_q;
  assign rx_err    = state_q == SCAN;
  assign err_cnt   = err_cnt_q;
`ifdef FRAME_CHECK_EN
  assign check_err = check_err_q;
`else
  assign check_err = 1'b0;
`endif

endmodule
